// File: rtl/router_fsm_ctrl_if.sv
// Signal bundle between the router input-port controller and its neighbours
// (source, synchronizer, register block). The FSM sits on the slave modport.
interface router_fsm_ctrl_if;
   // Handshake: the source presents a byte while pkt_valid=1, and that byte is
   // taken on a rising clk edge only when busy=0; with busy=1 it holds the byte.
   logic       pkt_valid;
   logic [1:0] din;
   logic       fifo_full;
   logic       e0;
   logic       e1;
   logic       e2;
   logic       sr0;
   logic       sr1;
   logic       sr2;
   logic       parity_done;
   logic       low_pkt_valid;

   logic       busy;
   logic       detect_addr;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       write_enb_reg;
   logic       rst_int_reg;
   logic [3:0] state_dbg;

   modport master (
      output pkt_valid, din, fifo_full, e0, e1, e2, sr0, sr1, sr2,
             parity_done, low_pkt_valid,
      input  busy, detect_addr, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, rst_int_reg, state_dbg
   );

   modport slave (
      input  pkt_valid, din, fifo_full, e0, e1, e2, sr0, sr1, sr2,
             parity_done, low_pkt_valid,
      output busy, detect_addr, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, rst_int_reg, state_dbg
   );
endinterface

// File: rtl/router_fsm_ctrl.sv
// Packet-reception FSM for the 1x3 router input port (Moore outputs).
// Optional feature macro: ROUTER_FSM_BAD_ADDR_DROP_EN (drop packets addressed to 3).
module router_fsm_ctrl (
   input logic              clk,
   input logic              rst,
   router_fsm_ctrl_if.slave bus
);

   typedef enum logic [3:0] {
      DECODE_ADDRESS     = 4'd0,
      LOAD_FIRST_DATA    = 4'd1,
      LOAD_DATA          = 4'd2,
      FIFO_FULL_STATE    = 4'd3,
      LOAD_AFTER_FULL    = 4'd4,
      LOAD_PARITY        = 4'd5,
      CHECK_PARITY_ERROR = 4'd6,
      WAIT_TILL_EMPTY    = 4'd7
`ifdef ROUTER_FSM_BAD_ADDR_DROP_EN
      ,
      DROP_PACKET        = 4'd8
`endif
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [1:0] addr_q;
   logic       din_empty;
   logic       sel_empty;
   logic       sel_sr;
   logic       abortable;

   // Header decode looks at the live address; later states use the captured one.
   always_comb begin
      din_empty = 1'b0;
      case (bus.din)
         2'd0:    din_empty = bus.e0;
         2'd1:    din_empty = bus.e1;
         2'd2:    din_empty = bus.e2;
         default: din_empty = 1'b0;
      endcase
   end

   always_comb begin
      sel_empty = 1'b0;
      sel_sr    = 1'b0;
      case (addr_q)
         2'd0:    begin sel_empty = bus.e0; sel_sr = bus.sr0; end
         2'd1:    begin sel_empty = bus.e1; sel_sr = bus.sr1; end
         2'd2:    begin sel_empty = bus.e2; sel_sr = bus.sr2; end
         default: begin sel_empty = 1'b0;   sel_sr = 1'b0;    end
      endcase
   end

`ifdef ROUTER_FSM_BAD_ADDR_DROP_EN
   assign abortable = (state != DECODE_ADDRESS) && (state != DROP_PACKET);
`else
   assign abortable = (state != DECODE_ADDRESS);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= DECODE_ADDRESS;
         addr_q <= 2'd0;
      end else begin
         state <= state_next;
         if (state == DECODE_ADDRESS && bus.pkt_valid && state_next != DECODE_ADDRESS)
            addr_q <= bus.din;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         DECODE_ADDRESS: begin
            if (bus.pkt_valid && bus.din != 2'd3)
               state_next = din_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
`ifdef ROUTER_FSM_BAD_ADDR_DROP_EN
            else if (bus.pkt_valid)
               state_next = DROP_PACKET;
`endif
         end
         LOAD_FIRST_DATA: state_next = LOAD_DATA;
         LOAD_DATA: begin
            if (bus.fifo_full)
               state_next = FIFO_FULL_STATE;
            else if (!bus.pkt_valid)
               state_next = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            if (!bus.fifo_full)
               state_next = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            if (bus.parity_done)
               state_next = DECODE_ADDRESS;
            else if (bus.low_pkt_valid)
               state_next = LOAD_PARITY;
            else
               state_next = LOAD_DATA;
         end
         LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR:
            state_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         WAIT_TILL_EMPTY: begin
            if (sel_empty)
               state_next = LOAD_FIRST_DATA;
         end
`ifdef ROUTER_FSM_BAD_ADDR_DROP_EN
         DROP_PACKET: begin
            if (!bus.pkt_valid)
               state_next = DECODE_ADDRESS;
         end
`endif
         default: state_next = DECODE_ADDRESS;
      endcase
      // A soft reset of the addressed FIFO abandons the packet from any state.
      if (abortable && sel_sr)
         state_next = DECODE_ADDRESS;
   end

   always_comb begin
      bus.detect_addr   = 1'b0;
      bus.lfd_state     = 1'b0;
      bus.ld_state      = 1'b0;
      bus.laf_state     = 1'b0;
      bus.full_state    = 1'b0;
      bus.rst_int_reg   = 1'b0;
      bus.write_enb_reg = 1'b0;
      bus.busy          = 1'b0;
      case (state)
         DECODE_ADDRESS:     bus.detect_addr = 1'b1;
         LOAD_FIRST_DATA:    begin bus.lfd_state = 1'b1; bus.busy = 1'b1; end
         LOAD_DATA:          begin bus.ld_state = 1'b1; bus.write_enb_reg = 1'b1; end
         FIFO_FULL_STATE:    begin bus.full_state = 1'b1; bus.busy = 1'b1; end
         LOAD_AFTER_FULL: begin
            bus.laf_state     = 1'b1;
            bus.write_enb_reg = 1'b1;
            bus.busy          = 1'b1;
         end
         LOAD_PARITY:        begin bus.write_enb_reg = 1'b1; bus.busy = 1'b1; end
         CHECK_PARITY_ERROR: begin bus.rst_int_reg = 1'b1; bus.busy = 1'b1; end
         WAIT_TILL_EMPTY:    bus.busy = 1'b1;
         default:            ;
      endcase
   end

   assign bus.state_dbg = state;

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Bench for router_fsm_ctrl: packet scenarios are expanded into per-cycle stimulus
// and expected output vectors, then replayed against the DUT.
module tb_router_fsm_ctrl;

   typedef struct packed {
      logic       pv;
      logic [1:0] din;
      logic       ff;
      logic [2:0] e;
      logic [2:0] sr;
      logic       pd;
      logic       lpv;
   } stim_t;

   // Output vector: {busy, detect_addr, lfd, ld, laf, full, write_enb, rst_int}
   localparam logic [7:0] V_DA  = 8'b0100_0000;
   localparam logic [7:0] V_LFD = 8'b1010_0000;
   localparam logic [7:0] V_LD  = 8'b0001_0010;
   localparam logic [7:0] V_FUL = 8'b1000_0100;
   localparam logic [7:0] V_LAF = 8'b1000_1010;
   localparam logic [7:0] V_LP  = 8'b1000_0010;
   localparam logic [7:0] V_CPE = 8'b1000_0001;
   localparam logic [7:0] V_WTE = 8'b1000_0000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   router_fsm_ctrl_if bus ();
   router_fsm_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   logic [7:0] obs;
   assign obs = {bus.busy, bus.detect_addr, bus.lfd_state, bus.ld_state,
                 bus.laf_state, bus.full_state, bus.write_enb_reg, bus.rst_int_reg};

   int checks   = 0;
   int failures = 0;

   stim_t      stim_q[$];
   logic [7:0] exp_q[$];
   string      tag_q[$];

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
      end
   endtask

   // Random don't-care inputs; the addressed FIFO's soft reset stays low.
   function automatic stim_t rnd_stim(input int a);
      stim_t      s;
      logic [11:0] r;
      r = 12'($urandom);
      s = r;
      if (a < 3) s.sr[a[1:0]] = 1'b0;
      return s;
   endfunction

   task automatic push(input stim_t s, input logic [7:0] e, input string tag);
      stim_q.push_back(s);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic drive(input stim_t s);
      bus.pkt_valid     = s.pv;
      bus.din           = s.din;
      bus.fifo_full     = s.ff;
      bus.e0            = s.e[0];
      bus.e1            = s.e[1];
      bus.e2            = s.e[2];
      bus.sr0           = s.sr[0];
      bus.sr1           = s.sr[1];
      bus.sr2           = s.sr[2];
      bus.parity_done   = s.pd;
      bus.low_pkt_valid = s.lpv;
   endtask

   task automatic push_idle(input int n);
      stim_t s;
      for (int i = 0; i < n; i++) begin
         s    = rnd_stim(3);
         s.pv = 1'b0;
         push(s, V_DA, "idle");
      end
   endtask

   // One packet: header, w wait cycles, n payload beats, optional stall/abort.
   task automatic gen_packet(input int a, input int w, input int n, input int stall_at,
                             input int d, input int mode, input int abort_at,
                             input bit cpe_full);
      stim_t s;
      bit    to_parity;
      to_parity = 1'b0;
      s = rnd_stim(a); s.pv = 1'b1; s.din = a[1:0]; s.e[a[1:0]] = (w == 0);
      push(s, (w == 0) ? V_LFD : V_WTE, "hdr");
      for (int j = 0; j < w; j++) begin
         s = rnd_stim(a); s.e[a[1:0]] = (j == w - 1);
         push(s, (j == w - 1) ? V_LFD : V_WTE, "wait");
      end
      s = rnd_stim(a);
      push(s, V_LD, "lfd");
      for (int k = 0; k < n; k++) begin
         if (k == abort_at) begin
            s = rnd_stim(a); s.sr[a[1:0]] = 1'b1;
            push(s, V_DA, "abort");
            push_idle(1);
            return;
         end
         if (k == stall_at) begin
            s = rnd_stim(a); s.ff = 1'b1;
            push(s, V_FUL, "full_rise");
            for (int i = 0; i < d - 1; i++) begin
               s = rnd_stim(a); s.ff = 1'b1;
               push(s, V_FUL, "full_hold");
            end
            s = rnd_stim(a); s.ff = 1'b0;
            push(s, V_LAF, "full_fall");
            s = rnd_stim(a); s.pd = (mode == 2); s.lpv = (mode == 1);
            if (mode == 2) begin
               push(s, V_DA, "laf_pd");
               push_idle(1);
               return;
            end else if (mode == 1) begin
               push(s, V_LP, "laf_lpv");
               to_parity = 1'b1;
               break;
            end
            push(s, V_LD, "laf_ld");
            continue;
         end
         s = rnd_stim(a); s.pv = 1'b1; s.ff = 1'b0;
         push(s, V_LD, "beat");
      end
      if (!to_parity) begin
         s = rnd_stim(a); s.pv = 1'b0; s.ff = 1'b0;
         push(s, V_LP, "last");
      end
      s = rnd_stim(a);
      push(s, V_CPE, "lp");
      s = rnd_stim(a); s.ff = cpe_full;
      push(s, cpe_full ? V_FUL : V_DA, "cpe");
      if (cpe_full) begin
         s = rnd_stim(a); s.ff = 1'b0;
         push(s, V_LAF, "cpe_full_fall");
         s = rnd_stim(a); s.pd = 1'b1;
         push(s, V_DA, "cpe_laf_pd");
      end
      push_idle($urandom_range(0, 2));
   endtask

   task automatic gen_random_packet();
      int n;
      n = $urandom_range(1, 6);
      gen_packet($urandom_range(0, 2),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                 n,
                 ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1,
                 $urandom_range(1, 3),
                 $urandom_range(0, 2),
                 ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1,
                 ($urandom_range(0, 3) == 0));
   endtask

   task automatic gen_bad_addr();
      stim_t s;
      int    m;
      m = $urandom_range(1, 4);
      s = rnd_stim(3); s.pv = 1'b1; s.din = 2'd3;
`ifdef ROUTER_FSM_BAD_ADDR_DROP_EN
      push(s, 8'h00, "bad_hdr");
      for (int i = 0; i < m; i++) begin
         s = rnd_stim(3); s.pv = 1'b1;
         push(s, 8'h00, "drop");
      end
      s = rnd_stim(3); s.pv = 1'b0;
      push(s, V_DA, "drop_end");
`else
      push(s, V_DA, "bad_hdr");
      for (int i = 0; i < m; i++) begin
         s = rnd_stim(3); s.pv = 1'b1; s.din = 2'd3;
         push(s, V_DA, "bad_stay");
      end
`endif
   endtask

   // Soft reset on FIFO b while a packet for address a is in LOAD_DATA.
   task automatic gen_sr_test(input int a, input int b);
      stim_t s;
      gen_packet(a, 0, 0, -1, 1, 0, -1, 1'b0);
      void'(stim_q.pop_back()); void'(exp_q.pop_back()); void'(tag_q.pop_back());
      void'(stim_q.pop_back()); void'(exp_q.pop_back()); void'(tag_q.pop_back());
      void'(stim_q.pop_back()); void'(exp_q.pop_back()); void'(tag_q.pop_back());
      stim_q.delete(); exp_q.delete(); tag_q.delete();
      s = rnd_stim(a); s.pv = 1'b1; s.din = a[1:0]; s.e[a[1:0]] = 1'b1;
      push(s, V_LFD, "sr_hdr");
      s = rnd_stim(a); push(s, V_LD, "sr_lfd");
      s = rnd_stim(a); s.pv = 1'b1; s.ff = 1'b0; s.sr = 3'b000; s.sr[b[1:0]] = 1'b1;
      push(s, (a == b) ? V_DA : V_LD, (a == b) ? "sr_abort" : "sr_other");
      if (a != b) begin
         s = rnd_stim(a); s.pv = 1'b0; s.ff = 1'b0; push(s, V_LP, "sr_last");
         s = rnd_stim(a); push(s, V_CPE, "sr_lp");
         s = rnd_stim(a); s.ff = 1'b0; push(s, V_DA, "sr_cpe");
      end
   endtask

   task automatic run_q();
      stim_t      s;
      logic [7:0] e;
      string      t;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         drive(s);
         @(posedge clk);
         #1;
         check(t, obs, e);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive('0);
      repeat (2) @(posedge clk);
      #1;
      check("reset", obs, V_DA);
      rst = 1'b0;

      // Reference packet: addr 1, pkt_valid high 5 cycles.
      gen_packet(1, 0, 4, -1, 1, 0, -1, 1'b0);
      run_q();
      // Stall on the 3rd payload beat, each LOAD_AFTER_FULL exit.
      for (int m = 0; m < 3; m++) begin
         gen_packet(0, 0, 4, 2, 2, m, -1, 1'b0);
         run_q();
      end
      gen_packet(2, 2, 3, -1, 1, 0, -1, 1'b0);
      run_q();
      gen_sr_test(0, 0);
      run_q();
      gen_sr_test(0, 1);
      run_q();
      gen_bad_addr();
      run_q();

      // Asynchronous reset in the middle of LOAD_DATA.
      gen_packet(2, 0, 6, -1, 1, 0, -1, 1'b0);
      repeat (6) begin
         void'(stim_q.pop_back()); void'(exp_q.pop_back()); void'(tag_q.pop_back());
      end
      run_q();
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", obs, V_DA);
      drive('0);
      @(posedge clk);
      #1;
      check("rst_hold", obs, V_DA);
      rst = 1'b0;
      gen_packet(1, 0, 2, -1, 1, 0, -1, 1'b0);
      run_q();

      for (int p = 0; p < 200; p++) begin
         if ($urandom_range(0, 9) == 0) gen_bad_addr();
         else                          gen_random_packet();
         run_q();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
